// File: rtl/wrb_port_arbiter.sv
// Two-port register-file writeback arbiter: round-robin picks up to two requesters with
// distinct nonzero destinations per cycle; address-0 writes are acked and dropped.
module wrb_port_arbiter #(
  parameter int NUM_REQ        = 7,
  parameter int REG_SIZE_WIDTH = 7,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*REG_SIZE_WIDTH-1:0]  req_address_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               wr_first_valid_o,
  output logic                               wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]          wr_first_address_o,
  output logic [REG_SIZE_WIDTH-1:0]          wr_second_address_o,
  output logic [DATA_WIDTH-1:0]              wr_first_data_o,
  output logic [DATA_WIDTH-1:0]              wr_second_data_o,
  output logic [15:0]                        conflict_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]          r_rr_ptr;
  logic                      r_wr1_vld;
  logic                      r_wr2_vld;
  logic [REG_SIZE_WIDTH-1:0] r_wr1_addr;
  logic [REG_SIZE_WIDTH-1:0] r_wr2_addr;
  logic [DATA_WIDTH-1:0]     r_wr1_data;
  logic [DATA_WIDTH-1:0]     r_wr2_data;
  logic [15:0]               r_conflict_cnt;

  logic [REG_SIZE_WIDTH-1:0] w_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]     w_data [NUM_REQ];
  logic [PTR_W-1:0]          w_idx  [NUM_REQ];

  // w_idx[k] is the k-th requester in scan order, starting at the round-robin pointer.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    logic [PTR_W:0] w_sum;
    assign w_addr[k] = req_address_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
    assign w_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_sum     = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
    assign w_idx[k]  = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
  end

  logic                      w_g0_vld;
  logic                      w_g1_vld;
  logic [PTR_W-1:0]          w_g0_idx;
  logic [PTR_W-1:0]          w_g1_idx;
  logic [REG_SIZE_WIDTH-1:0] w_g0_addr;
  logic [NUM_REQ-1:0]        w_ready;
  logic                      w_wait;
  logic [PTR_W-1:0]          w_last_idx;
  logic [PTR_W-1:0]          w_next_ptr;

  always_comb begin
    w_g0_vld  = 1'b0;
    w_g1_vld  = 1'b0;
    w_g0_idx  = '0;
    w_g1_idx  = '0;
    w_g0_addr = '0;
    w_ready   = '0;
    w_wait    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[w_idx[k]]) begin
        if (w_addr[w_idx[k]] == '0) begin
          w_ready[w_idx[k]] = 1'b1;
        end else if (!w_g0_vld) begin
          w_g0_vld          = 1'b1;
          w_g0_idx          = w_idx[k];
          w_g0_addr         = w_addr[w_idx[k]];
          w_ready[w_idx[k]] = 1'b1;
        end else if (!w_g1_vld && (w_addr[w_idx[k]] != w_g0_addr)) begin
          // Same-address requesters are skipped so both ports never hit one register.
          w_g1_vld          = 1'b1;
          w_g1_idx          = w_idx[k];
          w_ready[w_idx[k]] = 1'b1;
        end else begin
          w_wait = 1'b1;
        end
      end
    end
  end

  assign w_last_idx = w_g1_vld ? w_g1_idx : w_g0_idx;
  assign w_next_ptr = (w_last_idx == LAST_IDX) ? '0 : w_last_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_wr1_vld      <= 1'b0;
      r_wr2_vld      <= 1'b0;
      r_wr1_addr     <= '0;
      r_wr2_addr     <= '0;
      r_wr1_data     <= '0;
      r_wr2_data     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_wr1_vld <= w_g0_vld;
      r_wr2_vld <= w_g1_vld;
      if (w_g0_vld) begin
        r_wr1_addr <= w_addr[w_g0_idx];
        r_wr1_data <= w_data[w_g0_idx];
        r_rr_ptr   <= w_next_ptr;
      end
      if (w_g1_vld) begin
        r_wr2_addr <= w_addr[w_g1_idx];
        r_wr2_data <= w_data[w_g1_idx];
      end
      if (w_wait && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  // Gating with rst kills a grant registered just before reset before the regfile sees it.
  assign req_ready_o         = rst ? '0 : w_ready;
  assign wr_first_valid_o    = r_wr1_vld & ~rst;
  assign wr_second_valid_o   = r_wr2_vld & ~rst;
  assign wr_first_address_o  = r_wr1_addr;
  assign wr_second_address_o = r_wr2_addr;
  assign wr_first_data_o     = r_wr1_data;
  assign wr_second_data_o    = r_wr2_data;
  assign conflict_cnt_o      = r_conflict_cnt;

endmodule
